// File: rtl/alu.sv
// Registered 32-bit integer ALU for the MIPS datapath.
// The operation is selected by the R-type funct code. The LO result is
// driven on outpt and the HI result on outpt_hi. Both are loaded on a
// rising clock edge when En is high. All result logic is combinational
// and completes within one cycle, including multiply and divide.
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        En,
  input  logic [5:0]  Op_Code,
  input  logic [31:0] inpt1,
  input  logic [31:0] inpt2,
  output logic [31:0] outpt,
  output logic [31:0] outpt_hi,
  output logic        zero
);

  localparam logic [5:0] OP_SLL   = 6'h00;
  localparam logic [5:0] OP_SRL   = 6'h02;
  localparam logic [5:0] OP_SRA   = 6'h03;
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1A;
  localparam logic [5:0] OP_DIVU  = 6'h1B;
  localparam logic [5:0] OP_ADD   = 6'h20;
  localparam logic [5:0] OP_ADDU  = 6'h21;
  localparam logic [5:0] OP_SUB   = 6'h22;
  localparam logic [5:0] OP_SUBU  = 6'h23;
  localparam logic [5:0] OP_AND   = 6'h24;
  localparam logic [5:0] OP_OR    = 6'h25;
  localparam logic [5:0] OP_XOR   = 6'h26;
  localparam logic [5:0] OP_NOR   = 6'h27;
  localparam logic [5:0] OP_SLT   = 6'h2A;
  localparam logic [5:0] OP_SLTU  = 6'h2B;

  logic [31:0] outpt_q, outpt_d;
  logic [31:0] outpt_hi_q, outpt_hi_d;
  logic        zero_q, zero_d;

  // The shift amount comes only from the low five bits of operand B.
  logic [4:0] shamt;
  assign shamt = inpt2[4:0];

  // Both multipliers are 64-bit wide, so operands are extended
  // explicitly. The signed product then wraps to the correct two's
  // complement 64-bit result.
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  assign prod_s = $signed({{32{inpt1[31]}}, inpt1}) * $signed({{32{inpt2[31]}}, inpt2});
  assign prod_u = {32'h0, inpt1} * {32'h0, inpt2};

  // Division results are only used when the divisor is non-zero.
  // The signed overflow case is also steered away from these values,
  // so the divider never needs to define those corner cases itself.
  logic        div_by_zero;
  logic        div_ovf;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;
  assign div_by_zero = (inpt2 == 32'h0);
  assign div_ovf     = (inpt1 == 32'h8000_0000) && (inpt2 == 32'hFFFF_FFFF);
  assign quot_s      = $signed(inpt1) / $signed(inpt2);
  assign rem_s       = $signed(inpt1) % $signed(inpt2);
  assign quot_u      = inpt1 / inpt2;
  assign rem_u       = inpt1 % inpt2;

  logic signed [31:0] sra_res;
  assign sra_res = $signed(inpt1) >>> shamt;

  // Select the LO/HI results for the current opcode. Unknown codes give zero.
  always_comb begin
    outpt_d    = 32'h0;
    outpt_hi_d = 32'h0;
    unique case (Op_Code)
      OP_SLL:   outpt_d = inpt1 << shamt;
      OP_SRL:   outpt_d = inpt1 >> shamt;
      OP_SRA:   outpt_d = sra_res;
      OP_MULT: begin
        outpt_d    = prod_s[31:0];
        outpt_hi_d = prod_s[63:32];
      end
      OP_MULTU: begin
        outpt_d    = prod_u[31:0];
        outpt_hi_d = prod_u[63:32];
      end
      OP_DIV: begin
        if (div_by_zero) begin
          outpt_d    = 32'hFFFF_FFFF;
          outpt_hi_d = inpt1;
        end else if (div_ovf) begin
          outpt_d    = 32'h8000_0000;
          outpt_hi_d = 32'h0;
        end else begin
          outpt_d    = quot_s;
          outpt_hi_d = rem_s;
        end
      end
      OP_DIVU: begin
        if (div_by_zero) begin
          outpt_d    = 32'hFFFF_FFFF;
          outpt_hi_d = inpt1;
        end else begin
          outpt_d    = quot_u;
          outpt_hi_d = rem_u;
        end
      end
      OP_ADD, OP_ADDU: outpt_d = inpt1 + inpt2;
      OP_SUB, OP_SUBU: outpt_d = inpt1 - inpt2;
      OP_AND:   outpt_d = inpt1 & inpt2;
      OP_OR:    outpt_d = inpt1 | inpt2;
      OP_XOR:   outpt_d = inpt1 ^ inpt2;
      OP_NOR:   outpt_d = ~(inpt1 | inpt2);
      OP_SLT:   outpt_d = {31'h0, ($signed(inpt1) < $signed(inpt2))};
      OP_SLTU:  outpt_d = {31'h0, (inpt1 < inpt2)};
      default: begin
        outpt_d    = 32'h0;
        outpt_hi_d = 32'h0;
      end
    endcase
    zero_d = (outpt_d == 32'h0);
  end

  // Result registers: cleared asynchronously, loaded only when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outpt_q    <= 32'h0;
      outpt_hi_q <= 32'h0;
      zero_q     <= 1'b1;
    end else if (En) begin
      outpt_q    <= outpt_d;
      outpt_hi_q <= outpt_hi_d;
      zero_q     <= zero_d;
    end
  end

  assign outpt    = outpt_q;
  assign outpt_hi = outpt_hi_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, control sequences,
// and random operations compared against an arithmetic reference model.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic        En;
  logic [5:0]  Op_Code;
  logic [31:0] inpt1;
  logic [31:0] inpt2;
  logic [31:0] outpt;
  logic [31:0] outpt_hi;
  logic        zero;

  int checks = 0;
  int errors = 0;

  alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .En       (En),
    .Op_Code  (Op_Code),
    .inpt1    (inpt1),
    .inpt2    (inpt2),
    .outpt    (outpt),
    .outpt_hi (outpt_hi),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        z;
  } vec_t;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h required %08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [31:0] lo,
                           input logic [31:0] hi, input logic z);
    check32({name, "_lo"}, outpt, lo);
    check32({name, "_hi"}, outpt_hi, hi);
    check32({name, "_zero"}, {31'h0, zero}, {31'h0, z});
  endtask

  // Drive one operation with En=1, then sample just after the loading edge.
  task automatic apply(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Op_Code = op;
    inpt1   = a;
    inpt2   = b;
    En      = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Reference model. It works from numeric meaning (integer arithmetic
  // on wide values, powers of two for shifts) and not from bit operators
  // on the operand vectors.
  task automatic ref_model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] lo, output logic [31:0] hi);
    longint sa, sb, ua, ub, p, q, r, res;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    p  = longint'(1) << (ub % 32);
    lo = 32'h0;
    hi = 32'h0;
    res = 0;
    case (op)
      6'h00: begin res = (ua * p) % (longint'(1) << 32); lo = res[31:0]; end
      6'h02: begin res = ua / p; lo = res[31:0]; end
      6'h03: begin
        q = sa / p;
        if ((sa % p) != 0 && sa < 0) q = q - 1;
        lo = q[31:0];
      end
      6'h18: begin res = sa * sb; lo = res[31:0]; hi = res[63:32]; end
      6'h19: begin up = 64'(ua) * 64'(ub); lo = up[31:0]; hi = up[63:32]; end
      6'h1A, 6'h1B: begin
        if (b == 0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else if (op == 6'h1A) begin
          q = sa / sb; r = sa % sb;
          lo = q[31:0]; hi = r[31:0];
        end else begin
          q = ua / ub; r = ua % ub;
          lo = q[31:0]; hi = r[31:0];
        end
      end
      6'h20, 6'h21: begin res = ua + ub; lo = res[31:0]; end
      6'h22, 6'h23: begin res = ua - ub; lo = res[31:0]; end
      6'h24: lo = a & b;
      6'h25: lo = a | b;
      6'h26: lo = a ^ b;
      6'h27: lo = ~(a | b);
      6'h2A: lo = (sa < sb) ? 32'd1 : 32'd0;
      6'h2B: lo = (ua < ub) ? 32'd1 : 32'd0;
      default: begin lo = 32'h0; hi = 32'h0; end
    endcase
  endtask

  vec_t vecs[20];
  logic [5:0] valid_ops[17];

  initial begin
    logic [31:0] elo, ehi;
    logic [31:0] ra, rb;
    logic [5:0]  rop;

    vecs[0]  = '{6'h18, 32'd2, 32'd5, 32'd10, 32'd0, 1'b0};
    vecs[1]  = '{6'h19, 32'd2, 32'd5, 32'd10, 32'd0, 1'b0};
    vecs[2]  = '{6'h1A, 32'd2, 32'd5, 32'd0, 32'd2, 1'b1};
    vecs[3]  = '{6'h1B, 32'd2, 32'd5, 32'd0, 32'd2, 1'b1};
    vecs[4]  = '{6'h18, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0};
    vecs[5]  = '{6'h1A, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{6'h19, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'd1, 1'b0};
    vecs[7]  = '{6'h1B, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, 1'b0};
    vecs[8]  = '{6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0};
    vecs[9]  = '{6'h03, 32'h80000000, 32'd4, 32'hF8000000, 32'd0, 1'b0};
    vecs[10] = '{6'h20, 32'h7FFFFFFF, 32'd1, 32'h80000000, 32'd0, 1'b0};
    vecs[11] = '{6'h22, 32'd5, 32'd5, 32'd0, 32'd0, 1'b1};
    vecs[12] = '{6'h2A, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd0, 1'b0};
    vecs[13] = '{6'h2B, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 1'b1};
    vecs[14] = '{6'h27, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd0, 1'b0};
    vecs[15] = '{6'h3F, 32'd5, 32'd7, 32'd0, 32'd0, 1'b1};
    vecs[16] = '{6'h00, 32'h12345678, 32'hFFFFFFE0, 32'h12345678, 32'd0, 1'b0};
    vecs[17] = '{6'h02, 32'h80000000, 32'd31, 32'd1, 32'd0, 1'b0};
    vecs[18] = '{6'h1A, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0};
    vecs[19] = '{6'h1A, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0};

    valid_ops = '{6'h00, 6'h02, 6'h03, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20, 6'h21,
                  6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

    // Reset: rst_n goes low between edges, so the clear is asynchronous.
    rst_n   = 1'b1;
    En      = 1'b0;
    Op_Code = 6'h20;
    inpt1   = 32'h0;
    inpt2   = 32'h0;
    #2 rst_n = 1'b0;
    #1;
    check_all("reset", 32'h0, 32'h0, 1'b1);
    $display("txn reset lo=%08h hi=%08h z=%0d", outpt, outpt_hi, zero);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 20; i++) begin
      apply(vecs[i].op, vecs[i].a, vecs[i].b);
      $display("txn vec%0d op=%02h a=%08h b=%08h lo=%08h hi=%08h z=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, outpt, outpt_hi, zero);
      check_all($sformatf("vec%0d", i), vecs[i].lo, vecs[i].hi, vecs[i].z);
    end

    // Hold: with En=0, outputs stay put while the inputs keep changing.
    apply(6'h18, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check_all("hold_load", 32'd1, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      En      = 1'b0;
      Op_Code = 6'h27;
      inpt1   = $urandom;
      inpt2   = $urandom;
      @(posedge clk);
      #1;
      $display("txn hold%0d lo=%08h hi=%08h z=%0d", i, outpt, outpt_hi, zero);
      check_all($sformatf("hold%0d", i), 32'd1, 32'd0, 1'b0);
    end

    // Reset mid-stream: clears with no clock edge and stays cleared while held.
    apply(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check_all("prerst", 32'h00000001, 32'hFFFFFFFE, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check_all("midrst", 32'h0, 32'h0, 1'b1);
    Op_Code = 6'h20; inpt1 = 32'd3; inpt2 = 32'd4; En = 1'b1;
    @(posedge clk);
    #1;
    check_all("rst_held", 32'h0, 32'h0, 1'b1);
    $display("txn midreset lo=%08h hi=%08h z=%0d", outpt, outpt_hi, zero);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("first_load", 32'd7, 32'd0, 1'b0);

    // Random operations against the reference model.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(9) == 0) rop = 6'($urandom);
      else rop = valid_ops[$urandom_range(16)];
      case ($urandom_range(5))
        0: ra = 32'h80000000;
        1: ra = 32'($urandom_range(20));
        default: ra = $urandom;
      endcase
      case ($urandom_range(6))
        0: rb = 32'h0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'($urandom_range(40));
        default: rb = $urandom;
      endcase
      apply(rop, ra, rb);
      ref_model(rop, ra, rb, elo, ehi);
      $display("txn rnd%0d op=%02h a=%08h b=%08h lo=%08h hi=%08h z=%0d",
               i, rop, ra, rb, outpt, outpt_hi, zero);
      check_all($sformatf("rnd%0d", i), elo, ehi, (elo == 32'h0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Single-cycle registered 32-bit integer ALU for the MIPS datapath, selected by a 6-bit code equal to the MIPS R-type funct field. It computes logic, add/subtract, set-less-than, shift, multiply and divide results. Results register on the clock edge when enabled. The execute stage reads the low word from `outpt` and the HI word (product high half or remainder) from `outpt_hi`.

## Interface
- No parameters; datapath width fixed at 32.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `En`  in  1  result-register load enable.
- `Op_Code`  in  6  operation select (MIPS funct encoding).
- `inpt1`  in  32  operand A (rs).
- `inpt2`  in  32  operand B (rt); bits [4:0] give the shift amount for shifts.
- `outpt`  out  32  registered primary result (LO).
- `outpt_hi`  out  32  registered secondary result (HI).
- `zero`  out  1  registered flag; 1 when the value loaded into `outpt` is 0.

## Operation
Opcode map (result → `outpt`; `outpt_hi` is 0 unless stated):
- 0x00 SLL: `inpt1 << inpt2[4:0]`.
- 0x02 SRL: logical right shift of `inpt1` by `inpt2[4:0]`.
- 0x03 SRA: arithmetic right shift of `inpt1` by `inpt2[4:0]`.
- 0x18 MULT: signed 32×32 → 64-bit product; low word → `outpt`, high word → `outpt_hi`.
- 0x19 MULTU: the same as MULT with operands unsigned.
- 0x1A DIV: signed quotient → `outpt`, truncated toward zero; remainder → `outpt_hi`, with the sign of the dividend.
- 0x1B DIVU: unsigned quotient → `outpt`, remainder → `outpt_hi`.
- 0x20 ADD and 0x21 ADDU: `inpt1 + inpt2`, modulo 2^32. There is no overflow trap.
- 0x22 SUB and 0x23 SUBU: `inpt1 - inpt2`, modulo 2^32.
- 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR: bitwise.
- 0x2A SLT: 1 if `inpt1 < inpt2` as signed, else 0.
- 0x2B SLTU: the same comparison, unsigned.
- Any other code: both results 0 and `zero` = 1.

Boundary rules:
- Divide by zero, signed or unsigned: quotient 0xFFFFFFFF and remainder `inpt1`.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient 0x80000000 and remainder 0.
- A shift amount of 0 passes `inpt1` through unchanged. Bits [31:5] of `inpt2` are ignored for shifts.

## Timing
- The result logic is purely combinational from `inpt1`, `inpt2` and `Op_Code`.
- Rising `clk` with `En`=1 loads `outpt`, `outpt_hi` and `zero`. Latency is 1 cycle and throughput is one operation per cycle.
- With `En`=0, all outputs hold their previous values regardless of input changes.
- `rst_n`=0 immediately forces `outpt`=0, `outpt_hi`=0 and `zero`=1, independent of `clk`. Outputs stay in that state while `rst_n` is low.
- The first load happens on the first rising edge after `rst_n` deasserts with `En`=1.
- Reset asserted mid-stream discards the pending result; there is no partial state.
- Multiply and divide complete within one clock period. No handshake or busy signal exists.

## Test plan
- Multiply: `inpt1`=2, `inpt2`=5, `En`=1, codes 0x18 then 0x19 each held one cycle. Required after each edge: `outpt`=10, `outpt_hi`=0, `zero`=0.
- Divide: same operands, codes 0x1A then 0x1B. Required: `outpt`=0, `outpt_hi`=2, `zero`=1 for both.
- Signed multiply and divide:
  - MULT -3 (0xFFFFFFFD) × 7 → `outpt`=0xFFFFFFEB, `outpt_hi`=0xFFFFFFFF.
  - DIV -7 / 2 → `outpt`=0xFFFFFFFD, `outpt_hi`=0xFFFFFFFF.
  - MULTU 0xFFFFFFFF × 2 → `outpt`=0xFFFFFFFE, `outpt_hi`=1.
- Edge cases:
  - DIVU 9 / 0 → `outpt`=0xFFFFFFFF, `outpt_hi`=9.
  - DIV 0x80000000 / 0xFFFFFFFF → `outpt`=0x80000000, `outpt_hi`=0.
  - SRA 0x80000000 by 4 → `outpt`=0xF8000000.
- Arithmetic and logic:
  - ADD 0x7FFFFFFF + 1 → `outpt`=0x80000000.
  - SUB 5 - 5 → `outpt`=0, `zero`=1.
  - SLT -1 vs 1 → `outpt`=1.
  - SLTU -1 vs 1 → `outpt`=0.
  - NOR 0 with 0 → `outpt`=0xFFFFFFFF.
- Control:
  - With `En`=0, change operands and code: outputs unchanged over 3 edges.
  - Assert `rst_n`=0 between edges: outputs go to 0/0/1 without a clock edge.
  - Opcode 0x3F with `En`=1 → `outpt`=0, `outpt_hi`=0, `zero`=1.
